// File: rtl/pixel_frame_ctrl.sv
// Frame controller for the pixel sensor array: erase, expose, ADC ramp and row readout.
// Optional build macro PIXEL_GRAY_COUNT_EN selects a Gray-coded ADC count on the DATA bus.
`timescale 1ns/1ps
module pixel_frame_ctrl #(
    parameter int unsigned C_ERASE  = 5,
    parameter int unsigned C_EXPOSE = 255,
    parameter int unsigned NUM_ROWS = 2,
    parameter int unsigned ROW_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                erase,
    output logic                expose,
    output logic                ramp,
    output logic                convert,
    output logic [NUM_ROWS-1:0] read_sel,
    inout  wire  [7:0]          data,
    output logic [7:0]          pix_data,
    output logic [ROW_W-1:0]    pix_row,
    output logic                pix_valid,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_TURN,
        S_READ
    } state_t;

    state_t           state, state_nx;
    logic [31:0]      timer;
    logic [7:0]       count;
    logic             step_b;
    logic [ROW_W-1:0] row;
    logic             row_sample;
    logic             oe;

    function automatic logic [7:0] code(input logic [7:0] c);
`ifdef PIXEL_GRAY_COUNT_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    function automatic logic [7:0] decode(input logic [7:0] g);
        logic [7:0] b;
`ifdef PIXEL_GRAY_COUNT_EN
        b[7] = g[7];
        for (int unsigned i = 0; i < 7; i++)
            b[6-i] = b[7-i] ^ g[6-i];
`else
        b = g;
`endif
        return b;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_ERASE;
            S_ERASE:   if (timer == C_ERASE - 1) state_nx = S_EXPOSE;
            S_EXPOSE:  if (timer == C_EXPOSE - 1) state_nx = S_CONVERT;
            S_CONVERT: if (step_b && count == 8'hff) state_nx = S_TURN;
            S_TURN:    state_nx = S_READ;
            S_READ:    if (row_sample && row == ROW_W'(NUM_ROWS - 1)) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decode straight from state so reset clears them without waiting for an edge.
    always_comb begin
        erase    = (state == S_ERASE);
        expose   = (state == S_EXPOSE);
        convert  = (state == S_CONVERT);
        oe       = (state == S_CONVERT);
        ramp     = (state == S_CONVERT) && !step_b;
        busy     = (state != S_IDLE);
        read_sel = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++)
            read_sel[i] = (state == S_READ) && (row == ROW_W'(i));
    end

    assign data = oe ? code(count) : 'z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            count      <= '0;
            step_b     <= 1'b0;
            row        <= '0;
            row_sample <= 1'b0;
            pix_data   <= '0;
            pix_row    <= '0;
            pix_valid  <= 1'b0;
        end else begin
            state     <= state_nx;
            pix_valid <= 1'b0;
            if (state_nx != state)
                timer <= '0;
            else if (state == S_ERASE || state == S_EXPOSE)
                timer <= timer + 32'd1;
            case (state)
                S_EXPOSE: begin
                    count  <= '0;
                    step_b <= 1'b0;
                end
                S_CONVERT: begin
                    step_b <= !step_b;
                    // count saturates at 255 so the last step is held, never wrapped
                    if (step_b && count != 8'hff)
                        count <= count + 8'd1;
                end
                S_TURN: begin
                    row        <= '0;
                    row_sample <= 1'b0;
                end
                S_READ: begin
                    row_sample <= !row_sample;
                    if (row_sample) begin
                        pix_data  <= decode(data);
                        pix_row   <= row;
                        pix_valid <= 1'b1;
                        row       <= row + ROW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl with two threshold-latching pixel models on the DATA bus.
`timescale 1ns/1ps
module tb_pixel_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       erase, expose, ramp, convert;
    logic [1:0] read_sel;
    wire  [7:0] data;
    logic [7:0] pix_data;
    logic [3:0] pix_row;
    logic       pix_valid, busy;

    pixel_frame_ctrl #(
        .C_ERASE (5),
        .C_EXPOSE(255),
        .NUM_ROWS(2),
        .ROW_W   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .erase    (erase),
        .expose   (expose),
        .ramp     (ramp),
        .convert  (convert),
        .read_sel (read_sel),
        .data     (data),
        .pix_data (pix_data),
        .pix_row  (pix_row),
        .pix_valid(pix_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] code(input logic [7:0] c);
`ifdef PIXEL_GRAY_COUNT_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    // pixel models: latch the raw bus code on each ramp pulse while the step index <= threshold
    logic [7:0] lat [2] = '{8'h00, 8'h00};
    int         th  [2] = '{0, 0};
    int         ramp_cnt = 0;
    int         bus_err = 0;
    int         step_err = 0;
    int         viol = 0;
    logic [7:0] prev_bus = 8'h00;
    logic [7:0] bus100 = 8'h00;

    assign data = read_sel[0] ? lat[0] : 'z;
    assign data = read_sel[1] ? lat[1] : 'z;

    always @(negedge clk) begin
        if (erase) begin
            ramp_cnt <= 0;
            lat[0]   <= 8'h00;
            lat[1]   <= 8'h00;
        end
        if (ramp) begin
            if (ramp_cnt > 255 || data != code(ramp_cnt[7:0]))
                bus_err <= bus_err + 1;
`ifdef PIXEL_GRAY_COUNT_EN
            if (ramp_cnt > 0 && $countones(data ^ prev_bus) != 1)
                step_err <= step_err + 1;
`endif
            prev_bus <= data;
            if (ramp_cnt == 100) bus100 <= data;
            for (int r = 0; r < 2; r++)
                if (ramp_cnt <= th[r]) lat[r] <= data;
            ramp_cnt <= ramp_cnt + 1;
        end
        assert (!(dut.oe && read_sel != 2'b00))
            else $display("FAIL bus_rule: oe=%0b read_sel=%b at cyc %0d", dut.oe, read_sel, cyc);
        assert ($onehot0(read_sel))
            else $display("FAIL read_sel_onehot: read_sel=%b at cyc %0d", read_sel, cyc);
        assert (!(erase && expose))
            else $display("FAIL erase_expose: both high at cyc %0d", cyc);
        viol <= viol + ((dut.oe && read_sel != 2'b00) ? 1 : 0)
                     + ($onehot0(read_sel) ? 0 : 1)
                     + ((erase && expose) ? 1 : 0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int t0;
        int t1;
        int exp0;
        int exp1;
        int exp_lat0;
        int exp_lat1;
        int exp_ramps;
    } vec_t;

    vec_t vecs [4];

    task automatic run_frame(input vec_t v, input string nm);
        int n, nv, be0, se0;
        int off [2];
        int d   [2];
        int r   [2];
        int b   [2];
        th[0] = v.t0;
        th[1] = v.t1;
        off = '{-1, -1};
        d   = '{-1, -1};
        r   = '{-1, -1};
        b   = '{-1, -1};
        nv  = 0;
        @(negedge clk);
        start = 1'b1;
        n   = cyc;
        be0 = bus_err;
        se0 = step_err;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000 && nv < 2; k++) begin
            @(negedge clk);
            #1;
            if (pix_valid) begin
                off[nv] = cyc - n;
                d[nv]   = pix_data;
                r[nv]   = pix_row;
                b[nv]   = busy;
                nv++;
            end
        end
        chk({nm, "_nvalid"}, nv, 2);
        chk({nm, "_lat0"}, off[0], v.exp_lat0);
        chk({nm, "_row0"}, r[0], 0);
        chk({nm, "_data0"}, d[0], v.exp0);
        chk({nm, "_busy_at_v0"}, b[0], 1);
        chk({nm, "_lat1"}, off[1], v.exp_lat1);
        chk({nm, "_row1"}, r[1], 1);
        chk({nm, "_data1"}, d[1], v.exp1);
        chk({nm, "_busy_at_v1"}, b[1], 0);
        chk({nm, "_ramps"}, ramp_cnt, v.exp_ramps);
        chk({nm, "_bus_code_err"}, bus_err - be0, 0);
`ifdef PIXEL_GRAY_COUNT_EN
        chk({nm, "_gray_step_err"}, step_err - se0, 0);
        chk({nm, "_bus_at_100"}, bus100, 8'h56);
`else
        chk({nm, "_bus_at_100"}, bus100, 100);
`endif
        @(negedge clk);
        #1;
        chk({nm, "_valid_pulse_end"}, pix_valid, 0);
        chk({nm, "_hold_data"}, pix_data, v.exp1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, o, nv, busy_low, busy_low_at, first_erase, tail_idle, k;
        int off [4];
        int d   [4];

        vecs[0] = '{100,  37, 100,  37, 776, 778, 256};
        vecs[1] = '{  0, 255,   0, 255, 776, 778, 256};
        vecs[2] = '{255,   0, 255,   0, 776, 778, 256};
        vecs[3] = '{  1, 128,   1, 128, 776, 778, 256};

        // reset state
        #2;
        chk("rst_outs", {erase, expose, ramp, convert, read_sel, pix_valid, busy}, 0);
        chk("rst_oe", dut.oe, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_pix_row", pix_row, 0);
        #21;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++)
            run_frame(vecs[i], $sformatf("vec%0d", i));

        // reset in the middle of CONVERT, during phase A of count 0x40
        th[0] = 50;
        th[1] = 50;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 1000 && ramp_cnt != 65) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("midconv_reached", ramp_cnt, 65);
        chk("midconv_ramp", ramp, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("midconv_rst_outs", {erase, expose, ramp, convert, read_sel, pix_valid, busy}, 0);
        chk("midconv_rst_oe", dut.oe, 0);
        chk("midconv_rst_pix_data", pix_data, 0);
        chk("midconv_rst_pix_row", pix_row, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("midconv_stays_idle", busy, 0);
        run_frame(vecs[0], "after_rst");

        // start pulsed in EXPOSE is ignored; start held through frame end restarts immediately
        th[0] = 10;
        th[1] = 200;
        off = '{-1, -1, -1, -1};
        d   = '{-1, -1, -1, -1};
        @(negedge clk);
        start = 1'b1;
        n = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 100 && !expose) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("held_saw_expose", expose, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        busy_low = 0;
        busy_low_at = -1;
        first_erase = -1;
        tail_idle = 0;
        o = cyc - n;
        for (int j = 0; j < 2000 && o < 1570; j++) begin
            @(negedge clk);
            #1;
            o = cyc - n;
            if (o == 400) start = 1'b1;
            if (o == 1000) start = 1'b0;
            if (pix_valid && nv < 4) begin
                off[nv] = o;
                d[nv]   = pix_data;
                nv++;
            end
            if (!busy && o >= 2 && o <= 1555) begin
                busy_low++;
                busy_low_at = o;
            end
            if (erase && o > 778 && first_erase < 0) first_erase = o;
            if (!busy && o >= 1557 && o <= 1570) tail_idle++;
        end
        start = 1'b0;
        chk("held_nvalid", nv, 4);
        chk("held_lat0", off[0], 776);
        chk("held_lat1", off[1], 778);
        chk("held_lat2", off[2], 1554);
        chk("held_lat3", off[3], 1556);
        chk("held_data0", d[0], 10);
        chk("held_data1", d[1], 200);
        chk("held_data2", d[2], 10);
        chk("held_data3", d[3], 200);
        chk("held_busy_low_cycles", busy_low, 1);
        chk("held_busy_low_at", busy_low_at, 778);
        chk("held_next_erase", first_erase, 779);
        chk("held_tail_idle", tail_idle, 14);

        chk("assert_violations", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
